// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg
//   Shared definitions for the UART receive path: FIFO record width,
//   receiver state encodings, line-control bit indices, the record layout
//   and two small helpers (expected parity bit, character timeout threshold).
package uart_receiver_pkg;

   localparam int UART_FIFO_REC_WIDTH = 11;

   // lcr bit indices, shared with the transmitter
   localparam int UART_LC_SB = 2;
   localparam int UART_LC_PE = 3;
   localparam int UART_LC_EP = 4;
   localparam int UART_LC_SP = 5;

   typedef enum logic [2:0] {
      sr_idle       = 3'd0,
      sr_rec_start  = 3'd1,
      sr_rec_bit    = 3'd2,
      sr_rec_parity = 3'd3,
      sr_rec_stop   = 3'd4,
      sr_push       = 3'd5
   } rx_state_e;

   // One receive FIFO record: [10:3] data, [2] break, [1] parity err, [0] framing err
   typedef struct packed {
      logic [7:0] data;
      logic       bi;
      logic       pe;
      logic       fe;
   } rx_entry_t;

   // Expected parity bit. Data is right-aligned with zero upper bits, so the
   // full-byte XOR equals the XOR of the received bits.
   function automatic logic exp_parity(input logic [7:0] d, input logic ep, input logic sp);
      if (sp) return ~ep;
      return ep ? ^d : ~^d;
   endfunction

   // 64 x (7 + wl + sb + pe): four character times in 16x ticks
   function automatic logic [9:0] timeout_thr(input logic [1:0] wl, input logic sb, input logic pe);
      logic [3:0] n;
      n = 4'd7 + {2'b00, wl} + {3'b000, sb} + {3'b000, pe};
      return {n, 6'b000000};
   endfunction

endpackage

// File: rtl/uart_rfifo.sv
// uart_rfifo
//   Receive FIFO, UART_FIFO_REC_WIDTH bits wide. Owns storage, occupancy,
//   sticky overrun and a count of flagged entries for rf_error.
// Ports:
//   clk, wb_rst_i (async, active low)
//   data_in/push     - record to store; dropped (overrun set) when full
//   pop              - drop head; ignored when empty
//   fifo_reset       - synchronous flush, highest priority
//   reset_status     - clears overrun
//   data_out         - head record (0 when empty), combinational
//   count, overrun, error
module uart_rfifo
   import uart_receiver_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  rx_entry_t                      data_in,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           fifo_reset,
   input  logic                           reset_status,
   output logic [UART_FIFO_REC_WIDTH-1:0] data_out,
   output logic [CW-1:0]                  count,
   output logic                           overrun,
   output logic                           error
);

   localparam int AW = $clog2(DEPTH);

   logic [UART_FIFO_REC_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]                  wr_ptr, rd_ptr;
   logic [CW-1:0]                  err_cnt;
   logic [UART_FIFO_REC_WIDTH-1:0] head;
   logic                           empty, full, pop_ok, push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok = push & (~full | pop_ok);
   assign head    = mem[rd_ptr];

   assign data_out = empty ? '0 : head;
   assign error    = (err_cnt != '0);

   always_ff @(posedge clk)
      if (push_ok && !fifo_reset) mem[wr_ptr] <= data_in;

   always_ff @(posedge clk or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_cnt <= '0;
         overrun <= 1'b0;
      end else if (fifo_reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_cnt <= '0;
         overrun <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count + CW'(push_ok) - CW'(pop_ok);
         err_cnt <= err_cnt + CW'(push_ok && (data_in[2:0] != 3'b000))
                            - CW'(pop_ok && (head[2:0] != 3'b000));
         if (push && !push_ok) overrun <= 1'b1;
         else if (reset_status) overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel UART receiver. Oversamples srx_pad_i on the 16x-baud
//   enable tick, frames per lcr, and pushes {data, bi, pe, fe} into uart_rfifo.
// Ports:
//   clk, wb_rst_i (async, active low), enable (16x tick), lcr (line control)
//   srx_pad_i   - raw serial input, idle high
//   rf_pop      - pop FIFO head;  rx_reset - flush FIFO;  lsr_mask - clear overrun
//   rf_data_out - FIFO head;  rf_count, rf_overrun, rf_error - FIFO status
//   rx_timeout  - character timeout;  rstate - FSM state for debug
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter  int DEPTH               = 16,
   localparam int UART_FIFO_COUNTER_W = $clog2(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  logic                           enable,
   input  logic [7:0]                     lcr,
   input  logic                           srx_pad_i,
   input  logic                           rf_pop,
   input  logic                           rx_reset,
   input  logic                           lsr_mask,
   output logic [UART_FIFO_REC_WIDTH-1:0] rf_data_out,
   output logic [UART_FIFO_COUNTER_W-1:0] rf_count,
   output logic                           rf_overrun,
   output logic                           rf_error,
   output logic                           rx_timeout,
   output logic [2:0]                     rstate
);

   rx_state_e  state;
   logic [1:0] sync;
   logic       srx, srx_d;
   logic [3:0] tick;
   logic [2:0] bitc;
   logic [7:0] data;
   logic       par_bit, pe, fe;
   logic       rf_push;
   rx_entry_t  entry;
   logic [9:0] tcnt, thr;
   logic       unused_lcr;

   assign unused_lcr = ^lcr[7:6];
   assign srx        = sync[1];
   assign rstate     = state;

   always_ff @(posedge clk or negedge wb_rst_i)
      if (!wb_rst_i) sync <= 2'b11;
      else           sync <= {sync[0], srx_pad_i};

   // Previous line value tracks every tick in every state, so a line that
   // stays low across the end of a frame never looks like a new start edge.
   always_ff @(posedge clk or negedge wb_rst_i)
      if (!wb_rst_i)   srx_d <= 1'b1;
      else if (enable) srx_d <= srx;

   always_ff @(posedge clk or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state   <= sr_idle;
         tick    <= '0;
         bitc    <= '0;
         data    <= '0;
         par_bit <= 1'b0;
         pe      <= 1'b0;
         fe      <= 1'b0;
         rf_push <= 1'b0;
         entry   <= '0;
      end else begin
         rf_push <= 1'b0;
         if (state == sr_push) begin
            // break: data, parity (cleared when not received) and stop all low
            rf_push <= 1'b1;
            entry   <= '{data: data, bi: (data == 8'd0) & ~par_bit & fe, pe: pe, fe: fe};
            state   <= sr_idle;
         end else if (enable) begin
            unique case (state)
               sr_idle:
                  if (srx_d && !srx) begin
                     tick  <= 4'd7;
                     state <= sr_rec_start;
                  end
               sr_rec_start:
                  if (tick != 4'd0)  tick <= tick - 4'd1;
                  else if (srx)      state <= sr_idle;
                  else begin
                     tick    <= 4'd15;
                     bitc    <= '0;
                     data    <= '0;
                     par_bit <= 1'b0;
                     pe      <= 1'b0;
                     fe      <= 1'b0;
                     state   <= sr_rec_bit;
                  end
               sr_rec_bit:
                  if (tick != 4'd0) tick <= tick - 4'd1;
                  else begin
                     tick       <= 4'd15;
                     data[bitc] <= srx;
                     // >= so a mid-frame lcr change can never skip the exit
                     if (bitc >= 3'd4 + {1'b0, lcr[1:0]})
                        state <= lcr[UART_LC_PE] ? sr_rec_parity : sr_rec_stop;
                     else
                        bitc <= bitc + 3'd1;
                  end
               sr_rec_parity:
                  if (tick != 4'd0) tick <= tick - 4'd1;
                  else begin
                     tick    <= 4'd15;
                     par_bit <= srx;
                     pe      <= srx != exp_parity(data, lcr[UART_LC_EP], lcr[UART_LC_SP]);
                     state   <= sr_rec_stop;
                  end
               sr_rec_stop:
                  if (tick != 4'd0) tick <= tick - 4'd1;
                  else begin
                     fe    <= ~srx;
                     state <= sr_push;
                  end
               default: state <= sr_idle;
            endcase
         end
      end
   end

   // Character timeout: counts ticks since the last FIFO activity
   assign thr = timeout_thr(lcr[1:0], lcr[UART_LC_SB], lcr[UART_LC_PE]);

   always_ff @(posedge clk or negedge wb_rst_i) begin
      if (!wb_rst_i)
         tcnt <= '0;
      else if (rf_push || rf_pop || rx_reset || rf_count == '0)
         tcnt <= '0;
      else if (enable && tcnt < thr)
         tcnt <= tcnt + 10'd1;
   end

   assign rx_timeout = (tcnt >= thr) && (rf_count != '0);

   uart_rfifo #(.DEPTH(DEPTH), .CW(UART_FIFO_COUNTER_W)) u_rfifo (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .data_in      (entry),
      .push         (rf_push),
      .pop          (rf_pop),
      .fifo_reset   (rx_reset),
      .reset_status (lsr_mask),
      .data_out     (rf_data_out),
      .count        (rf_count),
      .overrun      (rf_overrun),
      .error        (rf_error)
   );

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  lcr = 8'h03;
   logic        srx_pad_i = 1'b1;
   logic        rf_pop;
   logic        rx_reset = 1'b0;
   logic        lsr_mask = 1'b0;
   logic [10:0] rf_data_out;
   logic [4:0]  rf_count;
   logic        rf_overrun, rf_error, rx_timeout;
   logic [2:0]  rstate;

   logic        mon_pop = 1'b0;
   logic        stim_pop = 1'b0;
   logic        auto_pop = 1'b1;
   assign rf_pop = mon_pop | stim_pop;

   int n_chk = 0;
   int n_fail = 0;
   logic [10:0] exp_q[$];

   uart_receiver #(.DEPTH(16)) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .lcr(lcr),
      .srx_pad_i(srx_pad_i), .rf_pop(rf_pop), .rx_reset(rx_reset),
      .lsr_mask(lsr_mask), .rf_data_out(rf_data_out), .rf_count(rf_count),
      .rf_overrun(rf_overrun), .rf_error(rf_error), .rx_timeout(rx_timeout),
      .rstate(rstate)
   );

   always #5 clk = ~clk;

   // 16x tick: one clk in four
   initial begin
      int ecnt = 0;
      forever begin
         @(negedge clk);
         enable = (ecnt == 0);
         ecnt = (ecnt + 1) % 4;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: whenever the FIFO holds data, compare head with the scoreboard and pop
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (auto_pop && wb_rst_i && rf_count != 5'd0) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_entry: got %0h, expected none", rf_data_out);
            end else begin
               e = exp_q.pop_front();
               chk("rx_entry", {21'd0, rf_data_out}, {21'd0, e});
            end
            mon_pop = 1'b1;
            @(negedge clk);
            mon_pop = 1'b0;
         end
      end
   end

   task automatic drive_bit(input logic b);
      srx_pad_i = b;
      repeat (64) @(negedge clk);
   endtask

   task automatic idle(input int nbits);
      srx_pad_i = 1'b1;
      repeat (64 * nbits) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pb, input bit stop);
      drive_bit(1'b0);
      for (int i = 0; i < nb; i++) drive_bit(d[i]);
      if (pen) drive_bit(pb);
      drive_bit(stop);
   endtask

   task automatic wait_drain(input string nm);
      int k = 0;
      while ((exp_q.size() != 0 || rf_count != 5'd0) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {27'd0, rf_count}, 32'd0);
      chk({nm, "_queue"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int n, k;
      repeat (3) @(negedge clk);
      // reset values
      chk("rst_rstate", {29'd0, rstate}, 32'd0);
      chk("rst_count", {27'd0, rf_count}, 32'd0);
      chk("rst_data", {21'd0, rf_data_out}, 32'd0);
      chk("rst_overrun", {31'd0, rf_overrun}, 32'd0);
      chk("rst_error", {31'd0, rf_error}, 32'd0);
      chk("rst_timeout", {31'd0, rx_timeout}, 32'd0);
      wb_rst_i = 1'b1;
      idle(2);

      // 8N1 0xA5
      lcr = 8'h03;
      exp_q.push_back(11'h528);
      send_frame(8'hA5, 8, 0, 0, 1); idle(2);
      // 7E1, 0x41 has even ones -> expected parity 0; send 1 then 0
      lcr = 8'h1A;
      exp_q.push_back(11'h20A);
      send_frame(8'h41, 7, 1, 1, 1); idle(2);
      exp_q.push_back(11'h208);
      send_frame(8'h41, 7, 1, 0, 1); idle(2);
      // 8N1 with stop bit low
      lcr = 8'h03;
      exp_q.push_back(11'h1E1);
      send_frame(8'h3C, 8, 0, 0, 0); idle(2);
      wait_drain("basic_drain");

      // line held low for two character times: exactly one break entry
      exp_q.push_back(11'h005);
      srx_pad_i = 1'b0;
      repeat (20 * 64) @(negedge clk);
      idle(2);
      wait_drain("break_drain");

      // 4-tick glitch: FSM arms, then rejects the start bit
      srx_pad_i = 1'b0;
      repeat (16) @(negedge clk);
      srx_pad_i = 1'b1;
      repeat (8) @(negedge clk);
      chk("glitch_armed", {29'd0, rstate}, 32'd1);
      repeat (48) @(negedge clk);
      chk("glitch_idle", {29'd0, rstate}, 32'd0);
      chk("glitch_count", {27'd0, rf_count}, 32'd0);

      // flagged entry then rx_reset flush
      auto_pop = 1'b0;
      send_frame(8'h77, 8, 0, 0, 0); idle(1);
      chk("flag_count", {27'd0, rf_count}, 32'd1);
      chk("flag_error", {31'd0, rf_error}, 32'd1);
      rx_reset = 1'b1; @(negedge clk); rx_reset = 1'b0;
      chk("flush_count", {27'd0, rf_count}, 32'd0);
      chk("flush_error", {31'd0, rf_error}, 32'd0);

      // fill 16, 17th overruns
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({8'h10 + 8'(i), 3'b000});
         send_frame(8'h10 + 8'(i), 8, 0, 0, 1); idle(1);
      end
      send_frame(8'hFF, 8, 0, 0, 1); idle(1);
      chk("full_count", {27'd0, rf_count}, 32'd16);
      chk("overrun_set", {31'd0, rf_overrun}, 32'd1);
      chk("overrun_head", {21'd0, rf_data_out}, 32'h080);
      lsr_mask = 1'b1; @(negedge clk); lsr_mask = 1'b0;
      chk("overrun_clr", {31'd0, rf_overrun}, 32'd0);
      auto_pop = 1'b1;
      wait_drain("fill_drain");

      // timeout: 8N1 threshold 640 ticks after the entry lands
      auto_pop = 1'b0;
      exp_q.push_back(11'h2D0);
      fork
         send_frame(8'h5A, 8, 0, 0, 1);
         begin
            k = 0;
            while (rf_count != 5'd1 && k < 3000) begin @(negedge clk); k++; end
            n = 0; k = 0;
            while (k < 4000) begin
               @(posedge clk);
               if (enable) n++;
               #1;
               if (rx_timeout) break;
               k++;
            end
            chk("timeout_ticks", n, 32'd640);
            chk("timeout_high", {31'd0, rx_timeout}, 32'd1);
         end
      join
      auto_pop = 1'b1;
      wait_drain("timeout_drain");
      chk("timeout_low", {31'd0, rx_timeout}, 32'd0);

      // reset mid-byte
      drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
      wb_rst_i = 1'b0;
      @(negedge clk);
      chk("midrst_rstate", {29'd0, rstate}, 32'd0);
      chk("midrst_count", {27'd0, rf_count}, 32'd0);
      chk("midrst_data", {21'd0, rf_data_out}, 32'd0);
      chk("midrst_overrun", {31'd0, rf_overrun}, 32'd0);
      chk("midrst_timeout", {31'd0, rx_timeout}, 32'd0);
      srx_pad_i = 1'b1;
      repeat (4) @(negedge clk);
      wb_rst_i = 1'b1;
      idle(12);
      chk("midrst_nopush", {27'd0, rf_count}, 32'd0);
      chk("midrst_idle", {29'd0, rstate}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
